uart_tx_scheduler: RTL
======================

// Module: uart_tx_scheduler
// PURPOSE
//  Shares one 8N1 UART transmitter (start/data_in/tx, no busy output) between N_REQ byte producers.
//  Arbitrates round-robin, latches the winner's byte and drives the transmitter's data_in stable for the whole frame.
//  Issues a 1-cycle start pulse, then times the frame internally, since the transmitter exposes no busy flag.
//  Sits between the producers and the transmitter; both share clk and reset.
// PARAMETERS
//  N_REQ         4     number of requesters (>=2)
//  BIT_CYCLES    5201  clk cycles per serial bit; must match the transmitter's bit period
//  GUARD_CYCLES  2     extra cycles after the frame before the next start may issue (>=1)
//  CNT_W         17    frame counter width; must hold 10*BIT_CYCLES+GUARD_CYCLES-1
// PORTS
//  clk        in   1          rising-edge clock
//  reset      in   1          asynchronous, active-high reset
//  req        in   N_REQ      level request per requester; held with its data until its ack
//  req_data   in   8*N_REQ    byte of requester i at [8*i+7:8*i]
//  ack        out  N_REQ      one-hot 1-cycle pulse: byte of requester i latched
//  grant_id   out  clog2(N)   index of the requester whose byte is currently owned
//  tx_start   out  1          to transmitter start; 1-cycle pulse per frame
//  tx_data    out  8          to transmitter data_in; stable from START until next grant
//  busy       out  1          high in START and WAIT
//  done       out  1          1-cycle pulse at end of frame window
// BEHAVIOUR
//  Reset (async): state=IDLE; ack=0, tx_start=0, busy=0, done=0, tx_data=8'h00, grant_id=0, counter=0, rr pointer=N_REQ-1.
//  FRAME_CYCLES = 10*BIT_CYCLES + GUARD_CYCLES; all outputs registered.
//  IDLE:  if |req at an edge, the winner w is the first set bit searching from (pointer+1) mod N_REQ upward with wrap.
//         At that edge: tx_data<=req_data[w], grant_id<=w, ack[w]<=1, tx_start<=1, busy<=1, pointer<=w, state<=START.
//         No request: remain in IDLE with all pulses at 0.
//  START: lasts exactly 1 cycle (tx_start=1, ack[w]=1); next edge: tx_start<=0, ack<=0, counter<=0, state<=WAIT.
//  WAIT:  counter increments each cycle. When counter==FRAME_CYCLES-1: done<=1, busy<=0, counter<=0, state<=IDLE.
//  done is high for the first IDLE cycle only; a grant may occur on that same cycle's closing edge.
//  Minimum start-to-start spacing is FRAME_CYCLES+2 cycles. This guarantees the transmitter has returned to idle
//    before it samples the next start; start is never held for more than one cycle, so no double frame.
//  req changes in START/WAIT are ignored. A req still high one cycle after its ack is not re-granted in the same frame.
//    If it is still high at the next IDLE, it is a new request.
//  Simultaneous requests: exactly one ack per frame; fairness: every active requester is served within N_REQ frames.
//  tx_data and grant_id hold their last values in IDLE.
//  Reset mid-frame aborts immediately; no done pulse; pointer restarts at N_REQ-1 (requester 0 first).
//  Illegal state encoding returns to IDLE.
// STRUCTURE
//  uart_pkg: UART_BIT_CYCLES=5201, frame bit count (10), scheduler state localparams (IDLE/START/WAIT, 2 bits).
//  Sub-module rr_arbiter (req, pointer -> one-hot grant + index), combinational, reused by later UART muxes.
//  Top: state register, frame counter, data/grant registers.
// TESTING  (unit tests at BIT_CYCLES=4, GUARD_CYCLES=2 -> FRAME_CYCLES=42, N_REQ=4)
//  1. req=4'b0001, data0=8'hA5 at t0 -> ack=0001 and tx_start high on t0+1 only, tx_data=A5, busy high 43 cycles, done at t0+44.
//  2. req=4'b1111 held, data i=8'h10+i -> grants in order 0,1,2,3,0; start pulses exactly 44 cycles apart.
//  3. After grant 2, req=4'b0101 -> next grant 0 (wrap), then 2; never two acks in one frame.
//  4. reset pulse at WAIT counter=20 -> all outputs 0 in the same cycle, no done; next req=0010 granted after release.
//  5. Integration at defaults with the transmitter, req0 byte 8'h3C -> tx line low for 5201, then LSB-first 0,0,1,1,1,1,0,0 each 5201 cycles, stop high; done after tx returns high.
//  6. req0 held high through a full frame -> exactly two frames, second start 52014 cycles after the first.

Source files
------------

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module : uart_pkg
// Brief  : Shared UART timing constants and scheduler state encoding.
// Rev    : 1.0  initial release
// ============================================================================
package uart_pkg;

    localparam int UART_BIT_CYCLES = 5201;
    localparam int UART_FRAME_BITS = 10;

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_START = 2'd1;
    localparam logic [1:0] c_ST_WAIT  = 2'd2;

endpackage
`default_nettype wire

// File: rtl/uart_tx_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module : uart_tx_scheduler_if
// Brief  : Producer-side request bus plus transmitter-side outputs of the scheduler.
// Rev    : 1.0  initial release
// ============================================================================
interface uart_tx_scheduler_if #(
    parameter int N_REQ = 4
);
    localparam int c_IDX_W = $clog2(N_REQ);

    logic [N_REQ-1:0]   req;
    logic [8*N_REQ-1:0] req_data;
    logic [N_REQ-1:0]   ack;
    logic [c_IDX_W-1:0] grant_id;
    logic               tx_start;
    logic [7:0]         tx_data;
    logic               busy;
    logic               done;

    modport master (
        output req, req_data,
        input  ack, grant_id, tx_start, tx_data, busy, done
    );

    modport slave (
        input  req, req_data,
        output ack, grant_id, tx_start, tx_data, busy, done
    );

endinterface
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module : rr_arbiter
// Brief  : Combinational round-robin pick, searching upward from pointer+1 with wrap.
// Rev    : 1.0  initial release
// ============================================================================
module rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int IDX_W = $clog2(N_REQ)
) (
    input  wire logic [N_REQ-1:0] req,
    input  wire logic [IDX_W-1:0] pointer,
    output logic      [N_REQ-1:0] grant,
    output logic      [IDX_W-1:0] grant_idx,
    output logic                  valid
);

    int w_best;
    int w_dist;

    // Distance 0 is the requester just after the pointer; the last granted one is farthest.
    always_comb begin
        w_best    = N_REQ;
        w_dist    = 0;
        grant_idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            w_dist = (i + N_REQ - 1 - int'(pointer)) % N_REQ;
            if (req[i] && (w_dist < w_best)) begin
                w_best    = w_dist;
                grant_idx = IDX_W'(i);
            end
        end
        valid = (w_best < N_REQ);
        grant = valid ? (N_REQ'(1) << grant_idx) : '0;
    end

endmodule
`default_nettype wire

// File: rtl/uart_tx_scheduler.sv
`default_nettype none
// ============================================================================
// Module : uart_tx_scheduler
// Brief  : Round-robin sharing of one busy-less 8N1 transmitter with internal frame timing.
// Rev    : 1.0  initial release
// ============================================================================
module uart_tx_scheduler
    import uart_pkg::*;
#(
    parameter int N_REQ        = 4,
    parameter int BIT_CYCLES   = UART_BIT_CYCLES,
    parameter int GUARD_CYCLES = 2,
    parameter int CNT_W        = 17
) (
    input  wire logic clk,
    input  wire logic reset,
    uart_tx_scheduler_if.slave bus
);

    localparam int               c_IDX_W        = $clog2(N_REQ);
    localparam int               c_FRAME_CYCLES = UART_FRAME_BITS * BIT_CYCLES + GUARD_CYCLES;
    localparam logic [CNT_W-1:0] c_CNT_LAST     = CNT_W'(c_FRAME_CYCLES - 1);

    logic [1:0]         r_state, w_state_nxt;
    logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
    logic [c_IDX_W-1:0] r_ptr, w_ptr_nxt;
    logic [N_REQ-1:0]   r_ack, w_ack_nxt;
    logic               r_start, w_start_nxt;
    logic               r_busy, w_busy_nxt;
    logic               r_done, w_done_nxt;
    logic [7:0]         r_data, w_data_nxt;
    logic [c_IDX_W-1:0] r_gid, w_gid_nxt;

    logic [N_REQ-1:0]   w_grant;
    logic [c_IDX_W-1:0] w_grant_idx;
    logic               w_grant_vld;
    logic [7:0]         w_sel_data;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .IDX_W (c_IDX_W)
    ) u_arb (
        .req       (bus.req),
        .pointer   (r_ptr),
        .grant     (w_grant),
        .grant_idx (w_grant_idx),
        .valid     (w_grant_vld)
    );

    always_comb begin
        w_sel_data = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_grant[i]) w_sel_data = bus.req_data[8*i +: 8];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= c_ST_IDLE;
            r_cnt   <= '0;
            r_ptr   <= c_IDX_W'(N_REQ - 1);
            r_ack   <= '0;
            r_start <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_data  <= 8'h00;
            r_gid   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_ptr   <= w_ptr_nxt;
            r_ack   <= w_ack_nxt;
            r_start <= w_start_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
            r_data  <= w_data_nxt;
            r_gid   <= w_gid_nxt;
        end
    end

    always_comb begin
        w_state_nxt = c_ST_IDLE;
        case (r_state)
            c_ST_IDLE:  w_state_nxt = w_grant_vld ? c_ST_START : c_ST_IDLE;
            c_ST_START: w_state_nxt = c_ST_WAIT;
            c_ST_WAIT:  w_state_nxt = (r_cnt == c_CNT_LAST) ? c_ST_IDLE : c_ST_WAIT;
            default:    w_state_nxt = c_ST_IDLE;
        endcase
    end

    // Next values of the registered outputs; data/grant/pointer hold unless a new grant lands.
    always_comb begin
        w_cnt_nxt   = r_cnt;
        w_ptr_nxt   = r_ptr;
        w_ack_nxt   = '0;
        w_start_nxt = 1'b0;
        w_busy_nxt  = 1'b0;
        w_done_nxt  = 1'b0;
        w_data_nxt  = r_data;
        w_gid_nxt   = r_gid;
        case (r_state)
            c_ST_IDLE: begin
                if (w_grant_vld) begin
                    w_ack_nxt   = w_grant;
                    w_start_nxt = 1'b1;
                    w_busy_nxt  = 1'b1;
                    w_data_nxt  = w_sel_data;
                    w_gid_nxt   = w_grant_idx;
                    w_ptr_nxt   = w_grant_idx;
                end
            end
            c_ST_START: begin
                w_busy_nxt = 1'b1;
                w_cnt_nxt  = '0;
            end
            c_ST_WAIT: begin
                if (r_cnt == c_CNT_LAST) begin
                    w_done_nxt = 1'b1;
                    w_cnt_nxt  = '0;
                end else begin
                    w_busy_nxt = 1'b1;
                    w_cnt_nxt  = r_cnt + 1'b1;
                end
            end
            default: begin
                w_cnt_nxt = '0;
            end
        endcase
    end

    assign bus.ack      = r_ack;
    assign bus.grant_id = r_gid;
    assign bus.tx_start = r_start;
    assign bus.tx_data  = r_data;
    assign bus.busy     = r_busy;
    assign bus.done     = r_done;

endmodule
`default_nettype wire
